control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/minisrc_pkg.sv | 48 ++++
 rtl/reg_select_decoder.sv | 13 +
 rtl/control_sequencer.sv | 147 ++++++++++++++
 tb/tb_control_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared encodings for the mini-SRC control sequencer: states, opcodes,
// ctrl bit positions and opcode classification helpers.
package minisrc_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int CTRL_W    = 12;
   localparam int C_PCOUT   = 0;
   localparam int C_PCIN    = 1;
   localparam int C_INCPC   = 2;
   localparam int C_MARIN   = 3;
   localparam int C_READ    = 4;
   localparam int C_MDRIN   = 5;
   localparam int C_MDROUT  = 6;
   localparam int C_IRIN    = 7;
   localparam int C_YIN     = 8;
   localparam int C_ZIN     = 9;
   localparam int C_ZLOWOUT = 10;
   localparam int C_COUT    = 11;

   function automatic logic is_itype(input logic [4:0] op);
      return op inside {OP_ADDI, OP_ANDI, OP_ORI};
   endfunction

   function automatic logic is_alu(input logic [4:0] op);
      return is_itype(op) || (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR});
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select with enable; all-zero when disabled.
module reg_select_decoder (
   input  logic        en_i,
   input  logic [3:0]  sel_i,
   output logic [15:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// Mini-SRC fetch/execute control sequencer: Moore FSM with a bounded
// memory wait in T1 and a sticky fault flag.
module control_sequencer
   import minisrc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                clock,
   input  logic                clear,
   input  logic                start,
   input  logic [31:0]         ir,
   input  logic                mem_ready,
   output logic [CTRL_W-1:0]   ctrl,
   output logic [15:0]         r_out,
   output logic [15:0]         r_in,
   output logic [4:0]          alu_op,
   output logic                run,
   output logic                fault
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);

   state_t        state_q;
   logic [CW-1:0] wait_q;
   logic          fault_q;

   logic [4:0] op;
   logic [3:0] ra, rb, rc;
   logic       unused_ir;

   assign op        = ir[31:27];
   assign ra        = ir[26:23];
   assign rb        = ir[22:19];
   assign rc        = ir[18:15];
   assign unused_ir = ^ir[14:0];

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         fault_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (start) state_q <= S_T0;
            S_T0: begin
               state_q <= S_T1;
               wait_q  <= '0;
            end
            // mem_ready takes priority over the timeout on the final wait cycle
            S_T1: begin
               if (mem_ready) begin
                  state_q <= S_T2;
               end else if (wait_q == CW'(TIMEOUT_CYCLES)) begin
                  state_q <= S_HALT;
                  fault_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            S_T2: state_q <= S_T3;
            S_T3: begin
               if (op == OP_HALT) begin
                  state_q <= S_HALT;
               end else if (op == OP_NOP) begin
                  state_q <= S_T0;
               end else if (!is_alu(op)) begin
                  state_q <= S_HALT;
                  fault_q <= 1'b1;
               end else begin
                  state_q <= S_T4;
               end
            end
            S_T4: state_q <= S_T5;
            S_T5: state_q <= start ? S_T0 : S_IDLE;
            S_HALT: state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   logic       rout_en, rin_en;
   logic [3:0] rout_sel;

   always_comb begin
      ctrl     = '0;
      alu_op   = '0;
      rout_en  = 1'b0;
      rout_sel = rb;
      rin_en   = 1'b0;
      case (state_q)
         S_T0: begin
            ctrl[C_PCOUT] = 1'b1;
            ctrl[C_MARIN] = 1'b1;
            ctrl[C_INCPC] = 1'b1;
            ctrl[C_ZIN]   = 1'b1;
         end
         S_T1: begin
            ctrl[C_ZLOWOUT] = 1'b1;
            ctrl[C_READ]    = 1'b1;
            ctrl[C_MDRIN]   = 1'b1;
            ctrl[C_PCIN]    = (wait_q == '0);
         end
         S_T2: begin
            ctrl[C_MDROUT] = 1'b1;
            ctrl[C_IRIN]   = 1'b1;
         end
         S_T3: begin
            if (is_alu(op)) begin
               rout_en      = 1'b1;
               ctrl[C_YIN] = 1'b1;
            end
         end
         S_T4: begin
            ctrl[C_ZIN] = 1'b1;
            alu_op      = op;
            if (is_itype(op)) begin
               ctrl[C_COUT] = 1'b1;
            end else begin
               rout_en  = 1'b1;
               rout_sel = rc;
            end
         end
         // R0 is hardwired, so its load enable is never raised
         S_T5: begin
            ctrl[C_ZLOWOUT] = 1'b1;
            rin_en          = (ra != 4'd0);
         end
         default: ;
      endcase
   end

   reg_select_decoder u_rout_dec (
      .en_i     (rout_en),
      .sel_i    (rout_sel),
      .onehot_o (r_out)
   );

   reg_select_decoder u_rin_dec (
      .en_i     (rin_en),
      .sel_i    (ra),
      .onehot_o (r_in)
   );

   assign run   = (state_q != S_IDLE) && (state_q != S_HALT);
   assign fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-cycle expected output traces built per instruction
// from the sequencing rules, driven by a vector table, corner sequences and random cases.
module tb_control_sequencer;

   localparam int TO = 15;

   localparam logic [11:0] B_PCOUT = 12'h001, B_PCIN = 12'h002, B_INCPC = 12'h004,
                           B_MARIN = 12'h008, B_READ = 12'h010, B_MDRIN = 12'h020,
                           B_MDROUT = 12'h040, B_IRIN = 12'h080, B_YIN = 12'h100,
                           B_ZIN = 12'h200, B_ZLOWOUT = 12'h400, B_COUT = 12'h800;

   typedef struct packed {
      logic [11:0] ctrl;
      logic [15:0] r_out;
      logic [15:0] r_in;
      logic [4:0]  alu_op;
      logic        run;
      logic        fault;
   } obs_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      int          d;          // T1 cycle index carrying mem_ready; > TO means never
      int          exp_runs;   // cycles with run=1
      logic        exp_fault;  // fault at end of trace
   } vec_t;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [31:0] ir = '0;
   logic        mem_ready = 1'b0;
   logic [11:0] ctrl;
   logic [15:0] r_out, r_in;
   logic [4:0]  alu_op;
   logic        run, fault;

   int n_checks = 0;
   int n_pass   = 0;

   obs_t exp_q[$];
   bit   mr_q[$];

   control_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clock     (clock),
      .clear     (clear),
      .start     (start),
      .ir        (ir),
      .mem_ready (mem_ready),
      .ctrl      (ctrl),
      .r_out     (r_out),
      .r_in      (r_in),
      .alu_op    (alu_op),
      .run       (run),
      .fault     (fault)
   );

   always #5 clock = ~clock;

   function automatic obs_t mk(input logic [11:0] c, input logic [15:0] ro, input logic [15:0] ri,
                               input logic [4:0] a, input logic rn, input logic f);
      obs_t o;
      o = {c, ro, ri, a, rn, f};
      return o;
   endfunction

   function automatic obs_t sample();
      return mk(ctrl, r_out, r_in, alu_op, run, fault);
   endfunction

   task automatic check(input string nm, input obs_t got, input obs_t want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got ctrl=%h r_out=%h r_in=%h alu=%b run=%b fault=%b, want ctrl=%h r_out=%h r_in=%h alu=%b run=%b fault=%b",
                    nm, got.ctrl, got.r_out, got.r_in, got.alu_op, got.run, got.fault,
                    want.ctrl, want.r_out, want.r_in, want.alu_op, want.run, want.fault);
   endtask

   task automatic check_int(input string nm, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d want %0d", nm, got, want);
   endtask

   function automatic bit legal_op(input logic [4:0] op);
      return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
                        5'b11010, 5'b11011};
   endfunction

   // Expected cycle-by-cycle outputs for one instruction started from IDLE.
   task automatic build(input logic [31:0] iv, input int d);
      logic [4:0]  op;
      logic [15:0] one;
      op  = iv[31:27];
      one = 16'h0001;
      exp_q.delete();
      mr_q.delete();
      exp_q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0, 0, 0, 1, 0)); mr_q.push_back(0);
      if (d > TO) begin
         for (int k = 0; k <= TO; k++) begin
            exp_q.push_back(mk(B_ZLOWOUT | B_READ | B_MDRIN | (k == 0 ? B_PCIN : 12'h0), 0, 0, 0, 1, 0));
            mr_q.push_back(0);
         end
         repeat (2) begin exp_q.push_back(mk(0, 0, 0, 0, 0, 1)); mr_q.push_back(0); end
         return;
      end
      for (int k = 0; k <= d; k++) begin
         exp_q.push_back(mk(B_ZLOWOUT | B_READ | B_MDRIN | (k == 0 ? B_PCIN : 12'h0), 0, 0, 0, 1, 0));
         mr_q.push_back(k == d);
      end
      exp_q.push_back(mk(B_MDROUT | B_IRIN, 0, 0, 0, 1, 0)); mr_q.push_back(0);
      if (op == 5'b11011 || !legal_op(op)) begin
         exp_q.push_back(mk(0, 0, 0, 0, 1, 0)); mr_q.push_back(0);
         repeat (2) begin exp_q.push_back(mk(0, 0, 0, 0, 0, !legal_op(op))); mr_q.push_back(0); end
         return;
      end
      if (op == 5'b11010) begin
         exp_q.push_back(mk(0, 0, 0, 0, 1, 0)); mr_q.push_back(0);
         exp_q.push_back(mk(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0, 0, 0, 1, 0)); mr_q.push_back(0);
         return;
      end
      exp_q.push_back(mk(B_YIN, one << iv[22:19], 0, 0, 1, 0)); mr_q.push_back(0);
      if (op inside {5'b01100, 5'b01101, 5'b01110})
         exp_q.push_back(mk(B_COUT | B_ZIN, 0, 0, op, 1, 0));
      else
         exp_q.push_back(mk(B_ZIN, one << iv[18:15], 0, op, 1, 0));
      mr_q.push_back(0);
      exp_q.push_back(mk(B_ZLOWOUT, 0, (iv[26:23] == 0) ? 16'h0 : (one << iv[26:23]), 0, 1, 0));
      mr_q.push_back(0);
      repeat (2) begin exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); mr_q.push_back(0); end
   endtask

   task automatic do_clear(input string nm);
      clear = 1'b0;
      @(posedge clock); #1;
      check({nm, "_clr"}, sample(), '0);
      clear = 1'b1;
   endtask

   // abort_at >= 0 pulls clear right after that trace entry is checked.
   task automatic run_case(input string nm, input logic [31:0] iv, input int d, input int abort_at,
                           output int runs, output logic last_fault);
      obs_t o;
      build(iv, d);
      ir = iv; start = 1'b1; runs = 0; last_fault = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         @(posedge clock); #1;
         o = sample();
         check($sformatf("%s[%0d]", nm, i), o, exp_q[i]);
         runs += int'(o.run);
         last_fault = o.fault;
         start = 1'b0;
         mem_ready = mr_q[i];
         if (i == abort_at) begin
            mem_ready = 1'b0;
            do_clear({nm, "_abort"});
            break;
         end
      end
      mem_ready = 1'b0;
      do_clear(nm);
   endtask

   vec_t vecs[$];

   initial begin
      int          runs;
      logic        lf;
      logic [4:0]  op;
      logic [4:0]  legal_list [7];
      logic [31:0] iv;

      vecs.push_back('{"add_r1_r2_r3", 32'h18918000, 0, 6, 1'b0});
      vecs.push_back('{"addi_wait4", 32'h62B01234, 3, 9, 1'b0});
      vecs.push_back('{"timeout", 32'h18918000, 99, TO + 2, 1'b1});
      vecs.push_back('{"ready_at_limit", 32'h18918000, TO, TO + 6, 1'b0});
      vecs.push_back('{"illegal_10111", 32'hB8000000, 0, 4, 1'b1});
      vecs.push_back('{"halt", 32'hD8000000, 0, 4, 1'b0});
      vecs.push_back('{"sub_ra_r0", 32'h20228000, 1, 7, 1'b0});
      vecs.push_back('{"nop", 32'hD0000000, 0, 5, 1'b0});
      vecs.push_back('{"andi_r15", 32'h6F880000, 2, 8, 1'b0});
      vecs.push_back('{"or_r7_r8_r9", 32'h33C48000, 0, 6, 1'b0});

      // reset state and IDLE hold
      repeat (2) @(posedge clock);
      #1 check("reset", sample(), '0);
      clear = 1'b1;
      repeat (3) begin
         @(posedge clock); #1;
         check("idle_hold", sample(), '0);
      end

      // clear mid-wait; the next wait must restart at zero (ready_at_limit follows)
      run_case("clr_in_t1", 32'h18918000, 10, 4, runs, lf);

      foreach (vecs[v]) begin
         run_case(vecs[v].name, vecs[v].ir, vecs[v].d, -1, runs, lf);
         check_int({vecs[v].name, "_runs"}, runs, vecs[v].exp_runs);
         check_int({vecs[v].name, "_fault"}, int'(lf), int'(vecs[v].exp_fault));
      end

      // clear during T4 (index 4 with immediate mem_ready)
      run_case("clr_in_t4", 32'h18918000, 0, 4, runs, lf);

      legal_list = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110};
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) op = 5'($urandom_range(0, 31));
         else op = legal_list[$urandom_range(0, 6)];
         iv = {op, 27'($urandom())};
         run_case($sformatf("rnd%0d", n), iv, int'($urandom_range(0, TO + 2)), -1, runs, lf);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
